// File: rtl/ram_responder_pkg.sv
// Shared definitions for the ram_responder slice: access mode encodings,
// default geometry/latency, and the responder FSM state type.
// Optional feature macro used elsewhere in the slice: RAM_STATS_EN.
package ram_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_DW      = 32;
  localparam int DEF_AW      = 12;
  localparam int DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ram_responder_if.sv
// Word request/response bus between an initiator (cache) and the RAM
// responder. The master modport is the initiator side, slave the responder.
// Optional feature macro of the slice: RAM_STATS_EN (not carried on this bus).
interface ram_responder_if #(
  parameter int DW = 32
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_mode;
  logic [31:0]   req_address;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_mode;
  logic [DW-1:0] resp_data;

  modport master (
    output req_valid, req_mode, req_address, req_data, resp_ready,
    input  req_ready, resp_valid, resp_mode, resp_data
  );

  modport slave (
    input  req_valid, req_mode, req_address, req_data, resp_ready,
    output req_ready, resp_valid, resp_mode, resp_data
  );

endinterface

// File: rtl/ram_responder_array.sv
// Single-port synchronous storage, DW x 2**AW, write enable and registered
// read. Contents are deliberately not reset so the array maps onto block RAM.
// Optional feature macro of the slice: RAM_STATS_EN (unused here).
module ram_array #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_reg;

  // Write port plus read-first registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_responder.sv
// Backing RAM responder: accepts one word request at a time, commits it after
// LATENCY cycles and holds the response until the initiator takes it.
// Optional feature macro: RAM_STATS_EN adds rd_count/wr_count commit counters.
module ram_responder
  import ram_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  ram_responder_if.slave   bus
`ifdef RAM_STATS_EN
  ,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
`endif
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg;
  logic          mode_reg;
  logic [AW-1:0] idx_reg;
  logic [DW-1:0] data_reg;
  logic          resp_mode_reg;
  logic [DW-1:0] resp_data_reg;

  logic          accept;
  logic          commit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  // Address bits above the index are intentionally ignored (wrap)
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_address[31:AW];

  assign accept = (state_reg == IDLE) && bus.req_valid;
  assign commit = (state_reg == BUSY) && (cnt_reg == 8'd0);
  assign mem_we = commit && (mode_reg == MODE_WRITE);

  // While idle the array is addressed straight from the bus, so the read
  // register already holds the requested word on the accept edge and a
  // single BUSY cycle (LATENCY = 1) still sees valid read data.
  assign mem_addr = (state_reg == IDLE) ? bus.req_address[AW-1:0] : idx_reg;

  ram_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (data_reg),
    .rdata (mem_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (commit) state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.req_ready  = (state_reg == IDLE);
    bus.resp_valid = (state_reg == RESP);
  end

  assign bus.resp_mode = resp_mode_reg;
  assign bus.resp_data = resp_data_reg;

  // Request buffer, latency counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= 8'd0;
      mode_reg      <= MODE_READ;
      idx_reg       <= '0;
      data_reg      <= '0;
      resp_mode_reg <= MODE_READ;
      resp_data_reg <= '0;
    end else begin
      if (accept) begin
        mode_reg <= bus.req_mode;
        idx_reg  <= bus.req_address[AW-1:0];
        data_reg <= bus.req_data;
        cnt_reg  <= LAT_M1;
      end else if (state_reg == BUSY && cnt_reg != 8'd0) begin
        cnt_reg <= cnt_reg - 8'd1;
      end
      if (commit) begin
        resp_mode_reg <= mode_reg;
        resp_data_reg <= (mode_reg == MODE_WRITE) ? data_reg : mem_rdata;
      end
    end
  end

`ifdef RAM_STATS_EN
  logic [15:0] rd_count_reg;
  logic [15:0] wr_count_reg;

  // Completed-access counters, free-running with natural 16-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_reg <= 16'd0;
      wr_count_reg <= 16'd0;
    end else if (commit) begin
      if (mode_reg == MODE_WRITE) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end else begin
        rd_count_reg <= rd_count_reg + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
// Build with RAM_STATS_EN defined to also exercise the commit counters.
module tb_ram_responder;
  import ram_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int LAT = 4;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_responder_if #(.DW(DW)) bus ();

`ifdef RAM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  ram_responder #(
    .DW      (DW),
    .AW      (AW),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RAM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Response monitor: compares every accepted response with the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp got mode=%0d data=%0d exp none", bus.resp_mode, bus.resp_data);
        end else begin
          e = sb.pop_front();
          $display("resp mode=%0d data=%0d (exp mode=%0d data=%0d)", bus.resp_mode, bus.resp_data, e.mode, e.data);
          chk("resp_mode", 64'(bus.resp_mode), 64'(e.mode));
          chk("resp_data", 64'(bus.resp_data), 64'(e.data));
        end
      end
    end
  end

  // Present one request and return just after its accept edge
  task automatic issue(input logic m, input logic [31:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout got=0 exp=1");
    end
    bus.req_valid   = 1'b1;
    bus.req_mode    = m;
    bus.req_address = a;
    bus.req_data    = d;
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.req_address = $urandom;
    bus.req_data    = $urandom;
    bus.req_mode    = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.req_ready && !bus.resp_valid) && n < 200);
    if (!(bus.req_ready && !bus.resp_valid)) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got req_ready=%0d resp_valid=%0d exp 1/0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic xfer(input logic m, input logic [31:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
    sb.push_back('{mode: m, data: exp_d});
    $display("req mode=%0d addr=%h data=%0d", m, a, d);
    issue(m, a, d);
    wait_idle();
  endtask

  // Directed stimulus
  initial begin
    int first;
    int k;
    bus.req_valid   = 1'b0;
    bus.req_mode    = 1'b0;
    bus.req_address = '0;
    bus.req_data    = '0;
    bus.resp_ready  = 1'b1;

    // Reset values, before any clock edge
    #2;
    chk("reset_outputs", {60'd0, bus.req_ready, bus.resp_valid, bus.resp_mode, 1'b0}, {60'd0, 4'b1000});
    chk("reset_resp_data", 64'(bus.resp_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write/readback at address 0
    xfer(MODE_WRITE, 32'd0, 32'd14528, 32'd14528);
    xfer(MODE_READ,  32'd0, 32'd0,     32'd14528);

    // Aliasing on index 3036
    xfer(MODE_WRITE, 32'hA7E5FBDC, 32'd526421, 32'd526421);
    xfer(MODE_READ,  32'h00000BDC, 32'd0,      32'd526421);
    xfer(MODE_WRITE, 32'hA7E5FBDC, 32'd14528,  32'd14528);
    xfer(MODE_READ,  32'hA7E5FBDC, 32'd0,      32'd14528);

    // Latency: resp_valid exactly LAT edges after acceptance
    sb.push_back('{mode: MODE_WRITE, data: 32'd25369366});
    $display("req mode=1 addr=%0d data=25369366 (latency)", 1001425);
    issue(MODE_WRITE, 32'd1001425, 32'd25369366);
    first = 0;
    k = 0;
    while (first == 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.resp_valid) first = k;
    end
    chk("latency_edges", 64'(first), 64'd4);
    @(posedge clk);
    #1;
    chk("post_hs_ready", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);
    xfer(MODE_READ, 32'd2001, 32'd0, 32'd25369366);

    // Backpressure: response held for 10 cycles with resp_ready low
    bus.resp_ready = 1'b0;
    sb.push_back('{mode: MODE_READ, data: 32'd25369366});
    $display("req mode=0 addr=2001 (backpressure)");
    issue(MODE_READ, 32'd2001, 32'd0);
    k = 0;
    while (!bus.resp_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {30'd0, bus.resp_valid, bus.req_ready, bus.resp_data},
          {30'd0, 1'b1, 1'b0, 32'd25369366});
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);

    // Reset two cycles into an in-flight write of 0 to index 2001
    $display("req mode=1 addr=2001 data=0 (dropped by reset)");
    issue(MODE_WRITE, 32'd2001, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_reset_outputs", {60'd0, bus.req_ready, bus.resp_valid, bus.resp_mode, 1'b0}, {60'd0, 4'b1000});
    chk("midop_reset_data", 64'(bus.resp_data), 64'd0);
`ifdef RAM_STATS_EN
    chk("midop_reset_stats", {32'd0, rd_count, wr_count}, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    xfer(MODE_READ, 32'd2001, 32'd0, 32'd25369366);

`ifdef RAM_STATS_EN
    // Commit counters: 5 writes, 3 reads from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xfer(MODE_WRITE, 32'(100 + i), 32'(1000 + 7 * i), 32'(1000 + 7 * i));
    end
    for (int i = 0; i < 3; i++) begin
      xfer(MODE_READ, 32'(100 + i), 32'd0, 32'(1000 + 7 * i));
    end
    chk("wr_count", 64'(wr_count), 64'd5);
    chk("rd_count", 64'(rd_count), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stats_reset", {32'd0, rd_count, wr_count}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    wait_idle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
